// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite responder over NUM_REGS registers; define AXI_SLV_ID_REG_EN for a read-only ID at index 0
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH*NUM_REGS-1:0] regs_out
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ID_VAL = DATA_WIDTH'(32'hA5A5_0001);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_SLV_ID_REG_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t r_wstate, w_wnext;
    r_state_t r_rstate, w_rnext;
    logic r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0] r_wstrb;
    logic [1:0] r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_in;
    logic [IW-1:0] w_widx, w_ridx;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;
    assign w_commit = r_wstate == W_IDLE && r_aw_held && r_w_held;
    assign w_widx   = r_awaddr[2 +: IW];
    assign w_wr_ok  = r_awaddr < LIMIT && !(ID_EN && w_widx == '0);
    assign w_ridx   = araddr[2 +: IW];
    assign w_rd_in  = araddr < LIMIT;
    assign w_rd_val = (ID_EN && w_ridx == '0) ? ID_VAL : r_regs[w_ridx];
    assign bvalid   = r_wstate == W_RESP;
    assign bresp    = r_bresp;
    assign rvalid   = r_rstate == R_DATA;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;

    // write FSM: accept AW/W independently while idle, wait for bready in W_RESP
    always_comb begin
        w_wnext = r_wstate;
        awready = 1'b0;
        wready  = 1'b0;
        if (r_wstate == W_IDLE) begin
            awready = !rst && !r_aw_held;
            wready  = !rst && !r_w_held;
            w_wnext = w_commit ? W_RESP : W_IDLE;
        end else begin
            w_wnext = bready ? W_IDLE : W_RESP;
        end
    end

    // read FSM: single-beat capture in R_IDLE, hold response until rready
    always_comb begin
        w_rnext = r_rstate;
        arready = 1'b0;
        if (r_rstate == R_IDLE) begin
            arready = !rst;
            w_rnext = w_ar_hs ? R_DATA : R_IDLE;
        end else begin
            w_rnext = rready ? R_IDLE : R_DATA;
        end
    end

    // state registers for both FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
        end
    end

    // write path: latch AW and W, commit byte-masked write once both are held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= OKAY;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wr_ok ? OKAY : SLVERR;
                if (w_wr_ok)
                    for (int b = 0; b < NB; b++)
                        if (r_wstrb[b]) r_regs[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    // read path: capture data and response on the AR handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_in ? w_rd_val : '0;
            r_rresp <= w_rd_in ? OKAY : SLVERR;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_out[DATA_WIDTH*i +: DATA_WIDTH] = (ID_EN && i == 0) ? ID_VAL : r_regs[i];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed scoreboard bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;
    localparam int N = 8;
    localparam logic [31:0] ID_VAL = 32'hA5A5_0001;
`ifdef AXI_SLV_ID_REG_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0] wstrb = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [32*N-1:0] regs_out;
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] mdl [N];

    always #5 clk = ~clk;

    axi_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(N)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    function automatic logic [31:0] mval(input int i);
        return (ID_EN && i == 0) ? ID_VAL : mdl[i];
    endfunction

    function automatic logic [32*N-1:0] flat();
        logic [32*N-1:0] f;
        for (int i = 0; i < N; i++) f[32*i +: 32] = mval(i);
        return f;
    endfunction

    function automatic logic [1:0] wresp(input logic [31:0] a);
        return (a >= 32'(4*N) || (ID_EN && a[4:2] == 3'd0)) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [33:0] rexp(input logic [31:0] a);
        return (a < 32'(4*N)) ? {2'b00, mval(int'(a[4:2]))} : {2'b10, 32'h0};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (wresp(a) == 2'b00)
            for (int b = 0; b < 4; b++) if (s[b]) mdl[a[4:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic pop_b(input string tag);
        if (exp_b.size() == 0) timeout({tag, "_empty"});
        else chk(tag, 256'(bresp), 256'(exp_b.pop_front()));
    endtask

    task automatic pop_r(input string tag);
        if (exp_r.size() == 0) timeout({tag, "_empty"});
        else chk(tag, 256'({rresp, rdata}), 256'(exp_r.pop_front()));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        exp_b.push_back(wresp(a));
        for (int n = 0; !(awready && wready); n++) begin
            if (n == 20) begin timeout("wr_hs"); break; end
            @(negedge clk);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("b_early", 256'(bvalid), 256'(0));
        model_write(a, d, s);
        @(negedge clk);
        chk("b_valid", 256'(bvalid), 256'(1));
        pop_b("bresp");
        chk("regs_out", 256'(regs_out), 256'(flat()));
        @(negedge clk);
        chk("b_done", 256'(bvalid), 256'(0));
    endtask

    task automatic do_read(input logic [31:0] a);
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        exp_r.push_back(rexp(a));
        for (int n = 0; !arready; n++) begin
            if (n == 20) begin timeout("rd_hs"); break; end
            @(negedge clk);
        end
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_valid", 256'(rvalid), 256'(1));
        pop_r("rdata");
        @(negedge clk);
        chk("r_done", 256'(rvalid), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_bvalid", 256'(bvalid), 256'(0));
        chk("rst_rvalid", 256'(rvalid), 256'(0));
        chk("rst_resp", 256'({bresp, rresp}), 256'(0));
        chk("rst_rdata", 256'(rdata), 256'(0));
        chk("rst_readies", 256'({awready, wready, arready}), 256'(0));
        chk("rst_regs", 256'(regs_out), 256'(flat()));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_readies", 256'({awready, wready, arready}), 256'(3'b111));
        for (int i = 0; i < N; i++) do_read(32'(4*i));
        do_write(32'h4, 32'hDEADBEEF, 4'hF);
        do_read(32'h4);
        // W leads AW by three cycles
        @(negedge clk);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
        exp_b.push_back(wresp(32'h8));
        chk("wf_wready", 256'(wready), 256'(1));
        @(negedge clk);
        wvalid = 1'b0;
        chk("wf_w_held", 256'(wready), 256'(0));
        repeat (2) @(negedge clk);
        awaddr = 32'h8; awvalid = 1'b1;
        chk("wf_awready", 256'(awready), 256'(1));
        chk("wf_no_b", 256'(bvalid), 256'(0));
        @(negedge clk);
        awvalid = 1'b0;
        model_write(32'h8, 32'h11223344, 4'b0101);
        chk("wf_b_early", 256'(bvalid), 256'(0));
        @(negedge clk);
        chk("wf_b_valid", 256'(bvalid), 256'(1));
        pop_b("wf_bresp");
        chk("wf_reg2", 256'(regs_out[95:64]), 256'(32'h00220044));
        @(negedge clk);
        chk("wf_b_done", 256'(bvalid), 256'(0));
        do_read(32'h8);
        do_write(32'h20, 32'h12345678, 4'hF);
        do_read(32'h20);
        do_write(32'h1C, 32'hCAFEF00D, 4'b1000);
        do_read(32'h1C);
        do_write(32'h18, 32'h12345678, 4'hF);
        do_write(32'h18, 32'hFFFFFFFF, 4'h0);
        do_read(32'h18);
        do_write(32'h0, 32'h55AA55AA, 4'hF);
        do_read(32'h0);
        // back-pressure on both response channels
        @(negedge clk);
        awaddr = 32'hC; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
        exp_b.push_back(wresp(32'hC));
        exp_r.push_back(rexp(32'h4));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(32'hC, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("st_bvalid", 256'(bvalid), 256'(1));
            chk("st_bresp", 256'(bresp), 256'(exp_b[0]));
            chk("st_rvalid", 256'(rvalid), 256'(1));
            chk("st_rdata", 256'({rresp, rdata}), 256'(exp_r[0]));
            chk("st_readies", 256'({awready, wready, arready}), 256'(0));
            @(negedge clk);
        end
        pop_b("st_bresp_pop");
        pop_r("st_rdata_pop");
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("st_done", 256'({bvalid, rvalid}), 256'(0));
        chk("st_regs", 256'(regs_out), 256'(flat()));
        // reset while responses are pending
        @(negedge clk);
        awaddr = 32'h10; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
        exp_b.push_back(wresp(32'h10));
        exp_r.push_back(rexp(32'h4));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("rr_pending", 256'({bvalid, rvalid}), 256'(2'b11));
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) mdl[i] = '0;
        exp_b.delete();
        exp_r.delete();
        chk("rr_valids", 256'({bvalid, rvalid}), 256'(0));
        chk("rr_readies", 256'({awready, wready, arready}), 256'(0));
        chk("rr_regs", 256'(regs_out), 256'(flat()));
        @(negedge clk);
        rst = 1'b0; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("rr_no_b", 256'(bvalid), 256'(0));
        for (int i = 0; i < N; i++) do_read(32'(4*i));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
